// File: rtl/brew_sequencer_if.sv
// Bus between the drink selector / front panel and the brew sequencer.
// Carries the drink code, start/cancel requests and the actuator and status
// outputs. The clock and reset stay plain ports on the sequencer itself.
interface brew_sequencer_if;
    logic [2:0] Brew_code;
    logic       Brew_start;
    logic       Brew_cancel;
    logic       Brew_heater;
    logic       Brew_water;
    logic       Brew_milk;
    logic       Brew_busy;
    logic       Brew_done;
    logic [2:0] Brew_state;

    // Controller side: issues requests, observes actuators and status.
    modport master (
        output Brew_code, Brew_start, Brew_cancel,
        input  Brew_heater, Brew_water, Brew_milk, Brew_busy, Brew_done, Brew_state
    );

    // Sequencer side.
    modport slave (
        input  Brew_code, Brew_start, Brew_cancel,
        output Brew_heater, Brew_water, Brew_milk, Brew_busy, Brew_done, Brew_state
    );
endinterface

// File: rtl/brew_sequencer.sv
// Timed brew sequencer: heat -> water -> (optional milk) -> done pulse.
// A start with code bit0 set latches the milk flag (code bit2) and runs each
// phase for its *_CYCLES count using one shared down-counter.
// Optional feature macro: BREW_CANCEL_EN -- when defined, Brew_cancel aborts
// an active phase straight back to IDLE with no done pulse; when undefined the
// cancel input is ignored.
module brew_sequencer #(
    parameter int CNT_W        = 8,
    parameter int HEAT_CYCLES  = 20,
    parameter int WATER_CYCLES = 40,
    parameter int MILK_CYCLES  = 15
) (
    input  logic               Brew_clk,
    input  logic               Brew_rst,
    brew_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HEAT  = 3'd1,
        S_WATER = 3'd2,
        S_MILK  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] HEAT_LD  = CNT_W'(HEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WATER_LD = CNT_W'(WATER_CYCLES - 1);
    localparam logic [CNT_W-1:0] MILK_LD  = CNT_W'(MILK_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_milk;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_milk_nxt;
    logic             w_cnt_zero;
    logic             w_unused;

    assign w_cnt_zero = (r_cnt == '0);

`ifdef BREW_CANCEL_EN
    assign w_unused = bus.Brew_code[1];
`else
    assign w_unused = ^{bus.Brew_code[1], bus.Brew_cancel};
`endif

    // State, phase counter and milk flag registers; reset overrides everything.
    always_ff @(posedge Brew_clk) begin
        if (Brew_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_milk  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_milk  <= w_milk_nxt;
        end
    end

    // Next-state and counter/flag update; counter only decrements while nonzero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_milk_nxt  = r_milk;
        case (r_state)
            S_IDLE: begin
                if (bus.Brew_start && bus.Brew_code[0]) begin
                    w_state_nxt = S_HEAT;
                    w_cnt_nxt   = HEAT_LD;
                    w_milk_nxt  = bus.Brew_code[2];
                end
            end
            S_HEAT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_WATER;
                    w_cnt_nxt   = WATER_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_WATER: begin
                if (w_cnt_zero) begin
                    if (r_milk) begin
                        w_state_nxt = S_MILK;
                        w_cnt_nxt   = MILK_LD;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_MILK: begin
                if (w_cnt_zero) w_state_nxt = S_DONE;
                else            w_cnt_nxt   = r_cnt - 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_milk_nxt  = 1'b0;
            end
            default: begin
                // Unreachable encodings fall back to a clean IDLE.
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_milk_nxt  = 1'b0;
            end
        endcase
`ifdef BREW_CANCEL_EN
        if (bus.Brew_cancel &&
            (r_state == S_HEAT || r_state == S_WATER || r_state == S_MILK)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_milk_nxt  = 1'b0;
        end
`endif
    end

    // Moore output decode from the registered state; one actuator at a time.
    always_comb begin
        bus.Brew_heater = 1'b0;
        bus.Brew_water  = 1'b0;
        bus.Brew_milk   = 1'b0;
        bus.Brew_done   = 1'b0;
        bus.Brew_busy   = (r_state != S_IDLE);
        bus.Brew_state  = r_state;
        case (r_state)
            S_HEAT:  bus.Brew_heater = 1'b1;
            S_WATER: bus.Brew_water  = 1'b1;
            S_MILK:  bus.Brew_milk   = 1'b1;
            S_DONE:  bus.Brew_done   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_brew_sequencer.sv
// Bench for brew_sequencer: timeline model (start edge + phase lengths),
// per-cycle compare, directed literal checkpoints, then random stimulus.
module tb_brew_sequencer;
    localparam int H = 4;
    localparam int W = 6;
    localparam int M = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    brew_sequencer_if bus ();

    brew_sequencer #(
        .CNT_W(8), .HEAT_CYCLES(H), .WATER_CYCLES(W), .MILK_CYCLES(M)
    ) dut (
        .Brew_clk (clk),
        .Brew_rst (rst),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk   = 1'b0;

    // Model: a brew is "start edge ms, milk flag mk"; everything else follows
    // from arithmetic on the phase lengths.
    bit m_act = 1'b0;
    int ms    = 0;
    bit mk    = 1'b0;

    function automatic int m_phase(int t);
        int off;
        int len;
        if (!m_act) return 0;
        off = t - ms;
        len = H + W + (mk ? M : 0);
        if (off < 1 || off > len + 1) return 0;
        if (off <= H)     return 1;
        if (off <= H + W) return 2;
        if (off <= len)   return 3;
        return 4;
    endfunction

    // Packed {state[2:0], heater, water, milk, busy, done}
    function automatic logic [7:0] m_exp(int t);
        case (m_phase(t))
            1:       return 8'b001_10010;
            2:       return 8'b010_01010;
            3:       return 8'b011_00110;
            4:       return 8'b100_00011;
            default: return 8'b000_00000;
        endcase
    endfunction

    logic [7:0] dut_pk;
    assign dut_pk = {bus.Brew_state, bus.Brew_heater, bus.Brew_water,
                     bus.Brew_milk, bus.Brew_busy, bus.Brew_done};

    // Model advance at each edge; cyc is the number of that edge.
    always @(posedge clk) begin
        int ph;
        ph = m_phase(cyc);
        cyc <= cyc + 1;
        if (rst) begin
            m_act <= 1'b0;
        end else if (ph == 0) begin
            if (bus.Brew_start && bus.Brew_code[0]) begin
                m_act <= 1'b1;
                ms    <= cyc;
                mk    <= bus.Brew_code[2];
            end
        end
`ifdef BREW_CANCEL_EN
        else if (bus.Brew_cancel && ph >= 1 && ph <= 3) begin
            m_act <= 1'b0;
        end
`endif
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk) begin
            tests++;
            if (dut_pk !== m_exp(cyc)) begin
                fails++;
                $display("FAIL cycle_cmp t=%0d got=%b want=%b", cyc, dut_pk, m_exp(cyc));
            end
        end
    end

    // Literal checkpoint: pins both the DUT and the model at cycle t.
    task automatic expect_at(input int t, input logic [7:0] want, input string nm);
        logic [7:0] mv;
        while (cyc < t) @(negedge clk);
        mv = m_exp(cyc);
        tests++;
        if (dut_pk !== want) begin
            fails++;
            $display("FAIL %s dut t=%0d got=%b want=%b", nm, cyc, dut_pk, want);
        end
        tests++;
        if (mv !== want) begin
            fails++;
            $display("FAIL %s model t=%0d got=%b want=%b", nm, cyc, mv, want);
        end
    endtask

    task automatic idle_gap(input int n);
        bus.Brew_start  = 1'b0;
        bus.Brew_cancel = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one edge; returns the edge number it is sampled at.
    task automatic pulse_start(input logic [2:0] code, output int s);
        bus.Brew_code  = code;
        bus.Brew_start = 1'b1;
        s = cyc;
        @(negedge clk);
        bus.Brew_start = 1'b0;
    endtask

    localparam logic [7:0] P_HEAT  = 8'b001_10010;
    localparam logic [7:0] P_WATER = 8'b010_01010;
    localparam logic [7:0] P_MILK  = 8'b011_00110;
    localparam logic [7:0] P_DONE  = 8'b100_00011;
    localparam logic [7:0] P_IDLE  = 8'b000_00000;

    initial begin
        int s;
        bus.Brew_code   = 3'b000;
        bus.Brew_start  = 1'b0;
        bus.Brew_cancel = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk = 1'b1;
        expect_at(cyc, P_IDLE, "reset");
        rst = 1'b0;
        @(negedge clk);

        // Plain coffee with a second start mid-brew (ignored).
        pulse_start(3'b001, s);
        expect_at(s + 1, P_HEAT, "plain_heat_first");
        expect_at(s + 4, P_HEAT, "plain_heat_last");
        expect_at(s + 5, P_WATER, "plain_water_first");
        bus.Brew_start = 1'b1;
        expect_at(s + 6, P_WATER, "plain_restart_ignored");
        bus.Brew_start = 1'b0;
        expect_at(s + 10, P_WATER, "plain_water_last");
        expect_at(s + 11, P_DONE, "plain_done");
        expect_at(s + 12, P_IDLE, "plain_idle");
        idle_gap(3);

        // Milk coffee; code changes mid-brew do not matter.
        pulse_start(3'b101, s);
        expect_at(s + 3, P_HEAT, "milk_heat");
        bus.Brew_code = 3'b000;
        expect_at(s + 10, P_WATER, "milk_water_last");
        expect_at(s + 11, P_MILK, "milk_first");
        expect_at(s + 13, P_MILK, "milk_last");
        expect_at(s + 14, P_DONE, "milk_done");
        expect_at(s + 15, P_IDLE, "milk_idle");
        idle_gap(3);

        // Codes without bit0 are ignored.
        pulse_start(3'b000, s);
        expect_at(s + 1, P_IDLE, "code000_ignored");
        pulse_start(3'b100, s);
        expect_at(s + 1, P_IDLE, "code100_ignored");
        idle_gap(2);

        // Cancel during water.
        pulse_start(3'b001, s);
        while (cyc < s + 7) @(negedge clk);
        bus.Brew_cancel = 1'b1;
        @(negedge clk);
        bus.Brew_cancel = 1'b0;
`ifdef BREW_CANCEL_EN
        expect_at(s + 8, P_IDLE, "cancel_idle");
        expect_at(s + 11, P_IDLE, "cancel_no_done");
`else
        expect_at(s + 8, P_WATER, "cancel_ignored");
        expect_at(s + 11, P_DONE, "cancel_ignored_done");
`endif
        idle_gap(4);

        // Reset mid-brew, then restart.
        pulse_start(3'b101, s);
        while (cyc < s + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_at(s + 7, P_IDLE, "rst_mid_brew");
        while (cyc < s + 9) @(negedge clk);
        bus.Brew_code  = 3'b001;
        bus.Brew_start = 1'b1;
        @(negedge clk);
        bus.Brew_start = 1'b0;
        expect_at(s + 10, P_HEAT, "restart_heat_first");
        expect_at(s + 13, P_HEAT, "restart_heat_last");
        expect_at(s + 14, P_WATER, "restart_water");
        idle_gap(16);

        // Back-to-back with start held high.
        bus.Brew_code  = 3'b001;
        bus.Brew_start = 1'b1;
        s = cyc;
        expect_at(s + 11, P_DONE, "b2b_first_done");
        expect_at(s + 12, P_IDLE, "b2b_gap_idle");
        expect_at(s + 13, P_HEAT, "b2b_second_heat");
        idle_gap(20);

        // Random traffic checked by the per-cycle compare.
        for (int i = 0; i < 3000; i++) begin
            bus.Brew_start  = ($urandom_range(3) == 0);
            bus.Brew_code   = 3'($urandom_range(7));
            bus.Brew_cancel = ($urandom_range(15) == 0);
            rst             = ($urandom_range(299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        idle_gap(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
